// File: rtl/multi_channel_event_counter.sv
// -----------------------------------------------------------------------------
// multi_channel_event_counter
//
// NCH independent event counters for debug/profiling. Each channel owns a
// run-time programmable prescaler (tick every div+1 events), a WIDTH-bit
// counter that either wraps or saturates, and a sticky overflow flag.
//
// Ports
//   Clk       in   clock, all state updates on the rising edge
//   Reset     in   synchronous, active-high reset
//   En        in   event strobe (one event per cycle)
//   Slt       in   channel the event belongs to
//   CfgWe     in   configuration write strobe
//   CfgCh     in   channel being configured
//   CfgDiv    in   new divisor (tick every CfgDiv+1 events)
//   CfgSat    in   new mode: 1 = saturate, 0 = wrap
//   Clr       in   per-channel clear strobe
//   ClrCh     in   channel to clear
//   RdEn      in   read request
//   RdCh      in   channel to read
//   RdData    out  registered count of the requested channel
//   RdValid   out  high for one cycle when RdData is valid
//   OvfFlags  out  sticky overflow flag per channel (bit c = channel c)
//
// Read port: no handshake and no backpressure. A request with RdEn at edge k
// returns the count held before edge k, with RdValid high for the cycle after
// edge k. Out-of-range channels read as 0. Without RdEn, RdData holds.
// -----------------------------------------------------------------------------
module multi_channel_event_counter #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 64,
    parameter int PW          = 8,
    parameter int DEFAULT_DIV = 0,
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [CW-1:0]    Slt,
    input  logic             CfgWe,
    input  logic [CW-1:0]    CfgCh,
    input  logic [PW-1:0]    CfgDiv,
    input  logic             CfgSat,
    input  logic             Clr,
    input  logic [CW-1:0]    ClrCh,
    input  logic             RdEn,
    input  logic [CW-1:0]    RdCh,
    output logic [WIDTH-1:0] RdData,
    output logic             RdValid,
    output logic [NCH-1:0]   OvfFlags
);

    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];
    logic [PW-1:0]    pre_q [NCH];
    logic [PW-1:0]    pre_d [NCH];
    logic [PW-1:0]    div_q [NCH];
    logic [PW-1:0]    div_d [NCH];
    logic [NCH-1:0]   sat_q, sat_d;
    logic [NCH-1:0]   ovf_q, ovf_d;

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;

    // Per-channel decode. Only indices 0..NCH-1 are decoded, so an
    // out-of-range index on any port matches no channel and is ignored.
    logic [NCH-1:0] clr_hit, cfg_hit, ev_hit;

    for (genvar g = 0; g < NCH; g++) begin : g_decode
        assign clr_hit[g] = Clr   && (ClrCh == CW'(g));
        assign cfg_hit[g] = CfgWe && (CfgCh == CW'(g));
        // Clear or configure on the same channel drops that channel's event.
        assign ev_hit[g]  = En && (Slt == CW'(g)) && !clr_hit[g] && !cfg_hit[g];
    end

    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_d[c] = cnt_q[c];
            pre_d[c] = pre_q[c];
            div_d[c] = div_q[c];
            sat_d[c] = sat_q[c];
            ovf_d[c] = ovf_q[c];

            if (ev_hit[c]) begin
                if (pre_q[c] == div_q[c]) begin
                    pre_d[c] = '0;
                    if (cnt_q[c] != '1) begin
                        cnt_d[c] = cnt_q[c] + WIDTH'(1);
                    end else begin
                        ovf_d[c] = 1'b1;
                        if (!sat_q[c]) begin
                            cnt_d[c] = '0;
                        end
                    end
                end else begin
                    pre_d[c] = pre_q[c] + PW'(1);
                end
            end

            // Clear and configure may hit the same channel together; both
            // apply since they touch disjoint fields apart from pre (0 in both).
            if (cfg_hit[c]) begin
                div_d[c] = CfgDiv;
                sat_d[c] = CfgSat;
                pre_d[c] = '0;
            end
            if (clr_hit[c]) begin
                cnt_d[c] = '0;
                pre_d[c] = '0;
                ovf_d[c] = 1'b0;
            end

            // Read returns the pre-update count; unmatched RdCh yields 0.
            if (RdCh == CW'(c)) begin
                rd_data_d = cnt_q[c];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
                pre_q[c] <= '0;
                div_q[c] <= PW'(DEFAULT_DIV);
            end
            sat_q      <= '0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
                pre_q[c] <= pre_d[c];
                div_q[c] <= div_d[c];
            end
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= RdEn;
            if (RdEn) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign RdData   = rd_data_q;
    assign RdValid  = rd_valid_q;
    assign OvfFlags = ovf_q;

endmodule

// File: tb/tb_multi_channel_event_counter.sv
// -----------------------------------------------------------------------------
// Testbench for multi_channel_event_counter.
// NCH=5 so that channel index 5 (3-bit select) is out of range; WIDTH=4 so
// wrap/saturate boundaries are reachable in a few events.
// -----------------------------------------------------------------------------
module tb_multi_channel_event_counter;

    localparam int NCH         = 5;
    localparam int WIDTH       = 4;
    localparam int PW          = 8;
    localparam int DEFAULT_DIV = 0;
    localparam int CW          = 3;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic             Reset;
    logic             En;
    logic [CW-1:0]    Slt;
    logic             CfgWe;
    logic [CW-1:0]    CfgCh;
    logic [PW-1:0]    CfgDiv;
    logic             CfgSat;
    logic             Clr;
    logic [CW-1:0]    ClrCh;
    logic             RdEn;
    logic [CW-1:0]    RdCh;
    logic [WIDTH-1:0] RdData;
    logic             RdValid;
    logic [NCH-1:0]   OvfFlags;

    multi_channel_event_counter #(
        .NCH(NCH), .WIDTH(WIDTH), .PW(PW), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .Clk(Clk), .Reset(Reset), .En(En), .Slt(Slt),
        .CfgWe(CfgWe), .CfgCh(CfgCh), .CfgDiv(CfgDiv), .CfgSat(CfgSat),
        .Clr(Clr), .ClrCh(ClrCh), .RdEn(RdEn), .RdCh(RdCh),
        .RdData(RdData), .RdValid(RdValid), .OvfFlags(OvfFlags)
    );

    // ---------------- scoreboard ----------------
    int               n_vec = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_rd = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; afterwards compare the read port against the scoreboard.
    task automatic tick();
        logic rd;
        logic rst;
        logic [WIDTH-1:0] e;
        rd  = RdEn && !Reset;
        rst = Reset;
        @(posedge Clk);
        #1;
        if (rst) last_rd = '0;
        if (rd) begin
            check("rd_valid", RdValid, 1'b1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underflow: read issued with empty expected queue");
            end else begin
                e = exp_q.pop_front();
                check("rd_data", RdData, e);
                last_rd = e;
            end
        end else begin
            check("rd_idle_valid", RdValid, 1'b0);
            check("rd_hold_data", RdData, last_rd);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        En = 0; CfgWe = 0; Clr = 0; RdEn = 0;
    endtask

    task automatic events(input int ch, input int n);
        En = 1; Slt = CW'(ch);
        repeat (n) tick();
        En = 0;
    endtask

    task automatic read(input int ch, input logic [WIDTH-1:0] exp);
        RdEn = 1; RdCh = CW'(ch);
        exp_q.push_back(exp);
        tick();
        RdEn = 0;
    endtask

    task automatic cfg(input int ch, input int div, input logic sat, input logic with_clr);
        CfgWe = 1; CfgCh = CW'(ch); CfgDiv = PW'(div); CfgSat = sat;
        Clr = with_clr; ClrCh = CW'(ch);
        tick();
        CfgWe = 0; Clr = 0;
    endtask

    task automatic clear(input int ch);
        Clr = 1; ClrCh = CW'(ch);
        tick();
        Clr = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int               ch;
        int               div;
        logic             sat;
        int               n;
        logic [WIDTH-1:0] exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        //           ch div sat   n    cnt    ovf
        tbl[0] = '{2,  0, 1'b0, 10, 4'd10, 1'b0};  // plain counting
        tbl[1] = '{0,  0, 1'b0, 17, 4'd1,  1'b1};  // wrap past max
        tbl[2] = '{0,  0, 1'b1, 17, 4'd15, 1'b1};  // saturate at max
        tbl[3] = '{3,  1, 1'b0,  7, 4'd3,  1'b0};  // divide by 2
        tbl[4] = '{4,  0, 1'b0, 15, 4'd15, 1'b0};  // reach max, no overflow
        tbl[5] = '{4,  0, 1'b0, 16, 4'd0,  1'b1};  // exactly one wrap
        tbl[6] = '{2,  2, 1'b1, 50, 4'd15, 1'b1};  // divide by 3, saturate
        tbl[7] = '{3,255, 1'b0,256, 4'd1,  1'b0};  // largest divisor

        Reset = 1; Slt = '0; CfgCh = '0; CfgDiv = '0; CfgSat = 0;
        ClrCh = '0; RdCh = '0;
        idle();

        // Reset state
        tick();
        tick();
        Reset = 0;
        tick();
        check("reset_rd_data", RdData, '0);
        check("reset_ovf", OvfFlags, '0);

        // 10 events on channel 2, then back-to-back reads of every channel
        events(2, 10);
        read(0, 4'd0);
        read(1, 4'd0);
        read(2, 4'd10);
        read(3, 4'd0);
        read(4, 4'd0);
        tick();

        // Divisor 3 on channel 1: ticks on events 4, 8, 12
        cfg(1, 3, 1'b0, 1'b0);
        events(1, 9);
        read(1, 4'd2);
        events(1, 1);
        read(1, 4'd2);
        events(1, 2);
        read(1, 4'd3);

        // Table: clear+configure a channel, count, read, check its flag
        for (int i = 0; i < 8; i++) begin
            cfg(tbl[i].ch, tbl[i].div, tbl[i].sat, 1'b1);
            events(tbl[i].ch, tbl[i].n);
            read(tbl[i].ch, tbl[i].exp_cnt);
            check($sformatf("vec%0d_ovf", i), OvfFlags[tbl[i].ch], tbl[i].exp_ovf);
        end

        // Clear a saturated, overflowed channel
        check("ch0_ovf_before_clr", OvfFlags[0], 1'b1);
        clear(0);
        check("ch0_ovf_after_clr", OvfFlags[0], 1'b0);
        read(0, 4'd0);

        // Same cycle: event + clear + read on channel 3 holding 5
        cfg(3, 0, 1'b0, 1'b1);
        events(3, 5);
        En = 1; Slt = 3; Clr = 1; ClrCh = 3; RdEn = 1; RdCh = 3;
        exp_q.push_back(4'd5);
        tick();
        idle();
        read(3, 4'd0);

        // Event on channel 0 with clear on channel 3: both take effect
        En = 1; Slt = 0; Clr = 1; ClrCh = 3;
        tick();
        idle();
        read(0, 4'd1);

        // Configure + event on same channel: event dropped, count kept
        CfgWe = 1; CfgCh = 0; CfgDiv = 0; CfgSat = 0; En = 1; Slt = 0;
        tick();
        idle();
        read(0, 4'd1);

        // Event + read on same channel: read sees pre-update value
        En = 1; Slt = 0; RdEn = 1; RdCh = 0;
        exp_q.push_back(4'd1);
        tick();
        idle();
        read(0, 4'd2);

        // Out-of-range index on every port
        En = 1; Slt = 5; CfgWe = 1; CfgCh = 5; CfgDiv = 7; CfgSat = 1;
        Clr = 1; ClrCh = 5; RdEn = 1; RdCh = 5;
        exp_q.push_back(4'd0);
        tick();
        idle();
        read(0, 4'd2);
        read(3, 4'd0);
        read(2, 4'd15);
        events(0, 1);
        read(0, 4'd3);
        check("ovf_vector", OvfFlags, 5'b10100);

        // Reset mid-operation with events and reads active
        cfg(1, 3, 1'b0, 1'b0);
        Reset = 1; En = 1; Slt = 1; RdEn = 1; RdCh = 2;
        tick();
        Reset = 0;
        idle();
        check("reset_mid_ovf", OvfFlags, '0);
        events(1, 1);
        read(1, 4'd1);
        read(2, 4'd0);
        read(4, 4'd0);
        tick();

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
